cynth_call_driver: RTL and testbench
====================================

Name: cynth_call_driver

Overview:
- Initiator side of the generated-function call protocol (`__start` / `__valid` / `__retval`).
- Accepts a call request from a caller or top-level harness and drives `callee_start` for a fixed number of cycles.
- Waits for `callee_valid`, captures `callee_retval`, and presents the result through a ready/valid response port.
- Aborts with a timeout flag if the callee never completes; used wherever a synthesized function is invoked by surrounding logic instead of a testbench.

Parameters:
- WIDTH, 32, width of callee return value and response data.
- START_CYCLES, 2, number of consecutive cycles `callee_start` is held high per call (legal range 1..255).
- TIMEOUT, 10000, maximum cycles spent in WAIT before abort (legal range 1..2^24-1).

Ports:
- `__clk` in 1: sole clock; all logic is on the rising edge.
- `__reset` in 1: asynchronous, active-high reset.
- `req_valid` in 1: caller requests a call.
- `req_ready` out 1: driver can accept a request; high only in IDLE.
- `callee_start` out 1: start pulse to the callee's `__start`.
- `callee_valid` in 1: callee's `__valid`.
- `callee_retval` in WIDTH: callee's `__retval`; sampled only when `callee_valid` is high.
- `resp_valid` out 1: response available.
- `resp_ready` in 1: caller accepts the response.
- `resp_retval` out WIDTH: captured return value; 0 on timeout.
- `resp_timeout` out 1: qualifies `resp_valid`; high means the call was aborted.
- `busy` out 1: high in any state other than IDLE.
- `call_count` out 16: number of completed responses (normal or timeout), wraps modulo 2^16.

Behaviour:
- Reset (asynchronous, while `__reset` is high):
  - State = IDLE; `callee_start`=0, `resp_valid`=0, `resp_retval`=0, `resp_timeout`=0, `call_count`=0, internal counters=0.
  - `req_ready`=1 and `busy`=0 once the reset is applied.
  - Reset asserted mid-call drops `callee_start` immediately and discards any pending result. No response is issued for the interrupted call.
- Request handshake: a request is accepted in the cycle `req_valid`=1 && `req_ready`=1. Next state is START.
- IDLE:
  - `req_ready`=1.
  - `callee_valid` is ignored; no capture occurs.
- START:
  - `callee_start`=1 for exactly START_CYCLES consecutive cycles; a start counter counts 0..START_CYCLES-1.
  - The timeout counter runs from the first START cycle.
  - `callee_valid`=1 in any START cycle, including the first, completes the call: capture `callee_retval`, deassert `callee_start` on the next cycle, go to RESP.
  - Otherwise go to WAIT after the last START cycle.
- WAIT:
  - `callee_start`=0; the timeout counter increments each cycle.
  - `callee_valid`=1: capture retval, `resp_timeout`=0, go to RESP.
  - Timeout counter reaches TIMEOUT without valid: `resp_retval`=0, `resp_timeout`=1, go to RESP.
  - `callee_valid` arriving in the same cycle as the timeout is a success; valid wins.
- RESP:
  - `resp_valid`=1; `resp_retval` and `resp_timeout` are held stable until the handshake.
  - `resp_ready`=1 completes the handshake: `call_count` increments, state returns to IDLE, and `resp_valid` drops the next cycle.
  - `callee_valid` pulses in RESP are ignored and do not overwrite the captured value.
- Latency:
  - Request acceptance edge to first `callee_start` high: 1 cycle.
  - `callee_valid` sampled to `resp_valid` high: 1 cycle.
  - Minimum call, with valid in the first START cycle: `resp_valid` high 2 cycles after acceptance.
- Back-to-back calls: no new request is accepted until the cycle after the RESP handshake (`req_ready` low in RESP). The minimum gap is one IDLE cycle.
- Counter widths: the start counter is 8 bits. The timeout counter is 24 bits, saturating, and is cleared on entry to START.

Test Plan:
- Basic call: callee returns 32'h0000002A with valid 5 cycles after the first start, `resp_ready` tied high. Required: `callee_start` high exactly 2 cycles, `resp_valid` one cycle after valid, `resp_retval`=0x2A, `resp_timeout`=0, `call_count`=1.
- Immediate completion: `callee_valid`=1 in the first START cycle with retval 0xDEADBEEF. Required: `callee_start` high 1 cycle only, `resp_valid` 2 cycles after acceptance, `resp_retval`=0xDEADBEEF.
- Timeout with TIMEOUT=20: callee never asserts valid. Required: `resp_valid` with `resp_timeout`=1 and `resp_retval`=0, 21 cycles after acceptance (20 counted cycles, then 1 cycle to RESP).
- Timeout tie with TIMEOUT=20: valid arrives in the same cycle the counter reaches 20, retval 7. Required: `resp_timeout`=0 and `resp_retval`=7.
- Backpressure: `resp_ready` held low for 10 cycles and a second `callee_valid` pulse with retval 9 in RESP. Required: `resp_valid` and `resp_retval` stable at the first value, `req_ready`=0 throughout, and a single `call_count` increment after `resp_ready`.
- Reset mid-WAIT: assert `__reset` asynchronously between clock edges. Required: `busy`, `callee_start`, and `resp_valid` drop without waiting for a clock edge, `call_count`=0, and the next request after reset behaves as the basic call.

Source files
------------

// File: rtl/cynth_call_driver.sv
// cynth_call_driver
// Initiator side of the generated-function call protocol (__start/__valid/__retval).
// Takes one call request, pulses callee_start for START_CYCLES cycles, waits for
// callee_valid (or aborts after TIMEOUT cycles), then offers the captured return
// value on a ready/valid response port.
//
// Ports:
//   __clk, __reset            clock (rising edge), async active-high reset
//   req_valid / req_ready     call request handshake (ready only in IDLE)
//   callee_start              start pulse to the callee
//   callee_valid, callee_retval  completion and return value from the callee
//   resp_valid / resp_ready   response handshake
//   resp_retval, resp_timeout captured value (0 on abort) and abort flag
//   busy                      high whenever not IDLE
//   call_count                completed responses, wraps at 2^16
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// START | callee_start high, counting START_CYCLES
// WAIT  | start released, waiting for callee_valid or timeout
// RESP  | response held until resp_ready
module cynth_call_driver #(
  parameter int WIDTH        = 32,
  parameter int START_CYCLES = 2,
  parameter int TIMEOUT      = 10000
) (
  input  logic             __clk,
  input  logic             __reset,
  input  logic             req_valid,
  output logic             req_ready,
  output logic             callee_start,
  input  logic             callee_valid,
  input  logic [WIDTH-1:0] callee_retval,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_retval,
  output logic             resp_timeout,
  output logic             busy,
  output logic [15:0]      call_count
);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_WAIT, ST_RESP} state_t;

  localparam logic [7:0]  START_LAST = 8'(START_CYCLES - 1);
  localparam logic [23:0] TO_LAST    = 24'(TIMEOUT - 1);

  state_t      state;
  logic [7:0]  start_cnt;
  logic [23:0] to_cnt;

  // Decoded straight from the state register so both follow reset asynchronously.
  assign req_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge __clk or posedge __reset) begin
    if (__reset) begin
      state        <= ST_IDLE;
      start_cnt    <= '0;
      to_cnt       <= '0;
      callee_start <= 1'b0;
      resp_valid   <= 1'b0;
      resp_retval  <= '0;
      resp_timeout <= 1'b0;
      call_count   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            state        <= ST_START;
            callee_start <= 1'b1;
            start_cnt    <= '0;
            to_cnt       <= '0;
          end
        end

        ST_START: begin
          if (to_cnt != '1) to_cnt <= to_cnt + 24'd1;
          if (callee_valid) begin
            callee_start <= 1'b0;
            resp_valid   <= 1'b1;
            resp_retval  <= callee_retval;
            resp_timeout <= 1'b0;
            state        <= ST_RESP;
          end else if (start_cnt == START_LAST) begin
            callee_start <= 1'b0;
            state        <= ST_WAIT;
          end else begin
            start_cnt <= start_cnt + 8'd1;
          end
        end

        ST_WAIT: begin
          if (to_cnt != '1) to_cnt <= to_cnt + 24'd1;
          // to_cnt holds the number of cycles already counted; this cycle is the
          // TIMEOUT-th when it equals TIMEOUT-1. A valid in that cycle still wins.
          if (callee_valid) begin
            resp_valid   <= 1'b1;
            resp_retval  <= callee_retval;
            resp_timeout <= 1'b0;
            state        <= ST_RESP;
          end else if (to_cnt >= TO_LAST) begin
            resp_valid   <= 1'b1;
            resp_retval  <= '0;
            resp_timeout <= 1'b1;
            state        <= ST_RESP;
          end
        end

        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            call_count <= call_count + 16'd1;
            state      <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cynth_call_driver.sv
module tb_cynth_call_driver;

  logic        __clk = 1'b0;
  logic        __reset;
  logic        req_valid;
  logic        req_ready;
  logic        callee_start;
  logic        callee_valid;
  logic [31:0] callee_retval;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_retval;
  logic        resp_timeout;
  logic        busy;
  logic [15:0] call_count;

  int checks = 0;
  int failures = 0;

  cynth_call_driver #(.WIDTH(32), .START_CYCLES(2), .TIMEOUT(20)) dut (
    .__clk        (__clk),
    .__reset      (__reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .callee_start (callee_start),
    .callee_valid (callee_valid),
    .callee_retval(callee_retval),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_retval  (resp_retval),
    .resp_timeout (resp_timeout),
    .busy         (busy),
    .call_count   (call_count)
  );

  always #5 __clk = ~__clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance to 1 ns after the next rising edge ("cycle n" = interval after edge n).
  task automatic step();
    @(posedge __clk);
    #1;
  endtask

  task automatic test_reset();
    __reset = 1'b1;
    req_valid = 1'b0; callee_valid = 1'b0; callee_retval = '0; resp_ready = 1'b1;
    #2;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (callee_start !== 1'b0) begin failures++; $display("FAIL reset_start got=%b exp=0", callee_start); end
    checks++; if (resp_valid !== 1'b0 || resp_timeout !== 1'b0) begin failures++; $display("FAIL reset_resp got v=%b t=%b exp 0 0", resp_valid, resp_timeout); end
    checks++; if (resp_retval !== 32'h0) begin failures++; $display("FAIL reset_retval got=%h exp=0", resp_retval); end
    checks++; if (call_count !== 16'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", call_count); end
    step(); step();
    #3 __reset = 1'b0;
    step();
  endtask

  // Valid 5 cycles after the first start cycle, resp_ready high.
  task automatic test_basic(input logic [15:0] exp_count);
    int starts = 0;
    int early = 0;
    resp_ready = 1'b1;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL basic_req_ready got=%b exp=1", req_ready); end
    req_valid = 1'b1;
    step();                       // cycle 1: first START cycle
    req_valid = 1'b0;
    checks++; if (callee_start !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL basic_start_latency got start=%b busy=%b exp 1 1", callee_start, busy); end
    for (int c = 1; c <= 6; c++) begin
      if (callee_start === 1'b1) starts++;
      if (resp_valid !== 1'b0) early++;
      if (c == 6) begin callee_valid = 1'b1; callee_retval = 32'h0000002A; end
      step();
    end
    callee_valid = 1'b0; callee_retval = 32'h0;
    checks++; if (starts != 2) begin failures++; $display("FAIL basic_start_cycles got=%0d exp=2", starts); end
    checks++; if (early != 0) begin failures++; $display("FAIL basic_early_resp got=%0d exp=0", early); end
    checks++; if (resp_valid !== 1'b1 || resp_retval !== 32'h2A || resp_timeout !== 1'b0) begin failures++; $display("FAIL basic_resp got v=%b r=%h t=%b exp v=1 r=0000002a t=0", resp_valid, resp_retval, resp_timeout); end
    step();
    checks++; if (resp_valid !== 1'b0 || call_count !== exp_count || req_ready !== 1'b1) begin failures++; $display("FAIL basic_done got v=%b cnt=%0d rdy=%b exp v=0 cnt=%0d rdy=1", resp_valid, call_count, req_ready, exp_count); end
  endtask

  task automatic test_immediate();
    req_valid = 1'b1;
    step();                       // cycle 1
    req_valid = 1'b0;
    checks++; if (callee_start !== 1'b1) begin failures++; $display("FAIL imm_start got=%b exp=1", callee_start); end
    callee_valid = 1'b1; callee_retval = 32'hDEADBEEF;
    step();                       // cycle 2
    callee_valid = 1'b0; callee_retval = 32'h0;
    checks++; if (callee_start !== 1'b0) begin failures++; $display("FAIL imm_start_len got=%b exp=0", callee_start); end
    checks++; if (resp_valid !== 1'b1 || resp_retval !== 32'hDEADBEEF || resp_timeout !== 1'b0) begin failures++; $display("FAIL imm_resp got v=%b r=%h t=%b exp v=1 r=deadbeef t=0", resp_valid, resp_retval, resp_timeout); end
    step();
    checks++; if (call_count !== 16'd2 || req_ready !== 1'b1) begin failures++; $display("FAIL imm_done got cnt=%0d rdy=%b exp cnt=2 rdy=1", call_count, req_ready); end
  endtask

  task automatic test_timeout();
    int early = 0;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (resp_valid !== 1'b0 || busy !== 1'b1) early++;
      step();
    end
    checks++; if (early != 0) begin failures++; $display("FAIL to_early got=%0d exp=0", early); end
    checks++; if (resp_valid !== 1'b1 || resp_timeout !== 1'b1 || resp_retval !== 32'h0) begin failures++; $display("FAIL to_resp got v=%b t=%b r=%h exp v=1 t=1 r=00000000", resp_valid, resp_timeout, resp_retval); end
    step();
    checks++; if (call_count !== 16'd3 || resp_valid !== 1'b0) begin failures++; $display("FAIL to_done got cnt=%0d v=%b exp cnt=3 v=0", call_count, resp_valid); end
  endtask

  task automatic test_timeout_tie();
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (c == 20) begin callee_valid = 1'b1; callee_retval = 32'd7; end
      step();
    end
    callee_valid = 1'b0; callee_retval = 32'h0;
    checks++; if (resp_valid !== 1'b1 || resp_timeout !== 1'b0 || resp_retval !== 32'd7) begin failures++; $display("FAIL tie_resp got v=%b t=%b r=%h exp v=1 t=0 r=00000007", resp_valid, resp_timeout, resp_retval); end
    step();
    checks++; if (call_count !== 16'd4) begin failures++; $display("FAIL tie_count got=%0d exp=4", call_count); end
  endtask

  task automatic test_backpressure();
    int bad = 0;
    resp_ready = 1'b0;
    req_valid = 1'b1;
    step();                       // cycle 1
    req_valid = 1'b0;
    step(); step();               // cycle 3 (WAIT)
    callee_valid = 1'b1; callee_retval = 32'h55;
    step();                       // cycle 4: RESP
    callee_valid = 1'b0;
    req_valid = 1'b1;             // must not be accepted while in RESP
    for (int c = 4; c <= 13; c++) begin
      if (c == 6) begin callee_valid = 1'b1; callee_retval = 32'd9; end
      if (c == 7) begin callee_valid = 1'b0; callee_retval = 32'h0; end
      if (resp_valid !== 1'b1 || resp_retval !== 32'h55 || req_ready !== 1'b0 || call_count !== 16'd4) bad++;
      if (c == 13) begin resp_ready = 1'b1; req_valid = 1'b0; end
      step();
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL bp_hold got bad_cycles=%0d exp=0", bad); end
    checks++; if (resp_valid !== 1'b0 || call_count !== 16'd5 || req_ready !== 1'b1) begin failures++; $display("FAIL bp_done got v=%b cnt=%0d rdy=%b exp v=0 cnt=5 rdy=1", resp_valid, call_count, req_ready); end
    step();
    checks++; if (call_count !== 16'd5 || busy !== 1'b0) begin failures++; $display("FAIL bp_single got cnt=%0d busy=%b exp cnt=5 busy=0", call_count, busy); end
  endtask

  task automatic test_reset_midwait();
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step(); step(); step();       // cycle 4: WAIT
    #3 __reset = 1'b1;            // between edges
    #1;
    checks++; if (busy !== 1'b0 || callee_start !== 1'b0 || resp_valid !== 1'b0) begin failures++; $display("FAIL rst_async got busy=%b start=%b v=%b exp 0 0 0", busy, callee_start, resp_valid); end
    checks++; if (call_count !== 16'd0 || req_ready !== 1'b1) begin failures++; $display("FAIL rst_count got cnt=%0d rdy=%b exp cnt=0 rdy=1", call_count, req_ready); end
    step();
    #3 __reset = 1'b0;
    step();
    test_basic(16'd1);
  endtask

  initial begin
    test_reset();
    test_basic(16'd1);
    test_immediate();
    test_timeout();
    test_timeout_tie();
    test_backpressure();
    test_reset_midwait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
